// File: rtl/dram_arb_pkg.sv
// Shared types for the two-port DRAM arbiter: FSM states and port indices.
package dram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN0  = 2'd1,
      OWN1  = 2'd2,
      LOCK1 = 2'd3
   } arb_state_t;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dram_arbiter.sv
// Two-port DRAM arbiter (CPU port 0, debug/loader port 1) with lock and starvation bound.
// Define DRAM_ARB_RR_EN for round-robin tie-break; default is fixed p0 priority.
module dram_arbiter
   import dram_arb_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int STARVE_MAX = 8,
   parameter int LOCK_MAX   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic [3:0]        p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [31:0]       p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [31:0]       p0_rdata,
   input  logic              p1_req,
   input  logic              p1_lock,
   input  logic [3:0]        p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [31:0]       p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [31:0]       p1_rdata,
   output logic [3:0]        dram_we,
   output logic [ADDR_W-1:0] dram_addr,
   output logic [31:0]       dram_wdata,
   input  logic [31:0]       dram_rdata,
   output logic              cpu_stall
);

   localparam int WW = $clog2(STARVE_MAX + 1);
   localparam int LW = $clog2(LOCK_MAX + 1);
   localparam logic [WW-1:0] W_MAX  = WW'(STARVE_MAX);
   localparam logic [LW-1:0] L_MAX  = LW'(LOCK_MAX);
   localparam logic [LW-1:0] L_LAST = LW'(LOCK_MAX - 1);

   arb_state_t        r_state;
   logic [WW-1:0]     r_wait0;
   logic [WW-1:0]     r_wait1;
   logic [LW-1:0]     r_lock_cnt;
   logic              r_rv0;
   logic              r_rv1;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
`ifdef DRAM_ARB_RR_EN
   logic              r_rr;
`endif

   logic              w_s0;
   logic              w_s1;
   logic              w_g0;
   logic              w_g1;
   logic              w_lock_exit;
   logic [3:0]        w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [31:0]       w_wdata;

   assign w_s0 = p0_req && (r_wait0 == W_MAX);
   assign w_s1 = p1_req && (r_wait1 == W_MAX);

   // Starvation overrides lock, lock overrides the tie-break.
   always_comb begin
      w_g0 = 1'b0;
      w_g1 = 1'b0;
      if (rst) begin
         w_g0 = 1'b0;
      end else if (w_s0) begin
         w_g0 = 1'b1;
      end else if (w_s1) begin
         w_g1 = 1'b1;
      end else if (r_state == LOCK1 && p1_req) begin
         w_g1 = 1'b1;
      end else if (p0_req && p1_req) begin
`ifdef DRAM_ARB_RR_EN
         if (r_rr == PORT1) w_g1 = 1'b1;
         else               w_g0 = 1'b1;
`else
         w_g0 = 1'b1;
`endif
      end else if (p0_req) begin
         w_g0 = 1'b1;
      end else if (p1_req) begin
         w_g1 = 1'b1;
      end
   end

   always_comb begin
      w_we    = 4'b0000;
      w_addr  = r_addr;
      w_wdata = r_wdata;
      if (w_g0) begin
         w_we    = p0_we;
         w_addr  = p0_addr;
         w_wdata = p0_wdata;
      end else if (w_g1) begin
         w_we    = p1_we;
         w_addr  = p1_addr;
         w_wdata = p1_wdata;
      end
   end

   assign w_lock_exit = !p1_lock || w_s0 || w_s1 ||
                        (w_g1 && r_lock_cnt == L_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_wait0    <= '0;
         r_wait1    <= '0;
         r_lock_cnt <= '0;
         r_rv0      <= 1'b0;
         r_rv1      <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
`ifdef DRAM_ARB_RR_EN
         r_rr       <= PORT0;
`endif
      end else begin
         r_rv0 <= w_g0 && (p0_we == 4'b0000);
         r_rv1 <= w_g1 && (p1_we == 4'b0000);
         if (w_g0 || w_g1) begin
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
         end
         if (!p0_req || w_g0)    r_wait0 <= '0;
         else if (r_wait0 != W_MAX) r_wait0 <= r_wait0 + WW'(1);
         if (!p1_req || w_g1)    r_wait1 <= '0;
         else if (r_wait1 != W_MAX) r_wait1 <= r_wait1 + WW'(1);
`ifdef DRAM_ARB_RR_EN
         if (w_g0)      r_rr <= PORT1;
         else if (w_g1) r_rr <= PORT0;
`endif
         unique case (r_state)
            LOCK1: begin
               if (w_lock_exit) begin
                  r_state    <= IDLE;
                  r_lock_cnt <= '0;
               end else if (w_g1 && r_lock_cnt != L_MAX) begin
                  r_lock_cnt <= r_lock_cnt + LW'(1);
               end
            end
            default: begin
               r_lock_cnt <= '0;
               if (w_g0)
                  r_state <= OWN0;
               else if (w_g1 && r_state == OWN1 && p1_lock)
                  r_state <= LOCK1;
               else if (w_g1)
                  r_state <= OWN1;
               else
                  r_state <= IDLE;
            end
         endcase
      end
   end

   assign p0_gnt     = w_g0;
   assign p1_gnt     = w_g1;
   assign p0_rvalid  = r_rv0;
   assign p1_rvalid  = r_rv1;
   assign p0_rdata   = r_rv0 ? dram_rdata : 32'h0;
   assign p1_rdata   = r_rv1 ? dram_rdata : 32'h0;
   assign dram_we    = w_we;
   assign dram_addr  = w_addr;
   assign dram_wdata = w_wdata;
   assign cpu_stall  = p0_req && !w_g0;

endmodule

// File: tb/tb_dram_arbiter.sv
// Randomized bench for dram_arbiter against a cycle-level reference model.
// Honors DRAM_ARB_RR_EN for the tie-break expectation.
module tb_dram_arbiter;
   import dram_arb_pkg::*;

   localparam int AW   = 16;
   localparam int SMAX = 8;
   localparam int LMAX = 16;
`ifdef DRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          p0_req, p1_req, p1_lock;
   logic [3:0]    p0_we, p1_we;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [31:0]   p0_wdata, p1_wdata, dram_rdata;
   logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, cpu_stall;
   logic [31:0]   p0_rdata, p1_rdata, dram_wdata;
   logic [3:0]    dram_we;
   logic [AW-1:0] dram_addr;

   always #5 clk = ~clk;

   dram_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX), .LOCK_MAX(LMAX)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
      .p1_rdata(p1_rdata), .dram_we(dram_we), .dram_addr(dram_addr),
      .dram_wdata(dram_wdata), .dram_rdata(dram_rdata), .cpu_stall(cpu_stall)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model state
   int            m_wait [2];
   bit            m_locked;
   int            m_beats;
   int            m_owner;
   bit            m_ptr;
   bit            m_rv [2];
   logic [31:0]   m_rd [2];
   logic [AW-1:0] m_addr;
   logic [31:0]   m_wdata;
   logic [31:0]   ref_mem [16];
   logic [31:0]   dram_mem [16];

   logic          obs_g0, obs_g1, obs_stall, obs_rv0, obs_rv1;
   logic [3:0]    obs_we;
   logic [AW-1:0] obs_addr;
   logic [31:0]   obs_wdata, obs_rd0, obs_rd1;

   function automatic logic [31:0] merge(input logic [31:0] o,
                                         input logic [31:0] d,
                                         input logic [3:0] we);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++)
         if (we[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   task automatic m_reset();
      m_wait[0] = 0; m_wait[1] = 0;
      m_locked = 0; m_beats = 0; m_owner = -1; m_ptr = 0;
      m_rv[0] = 0; m_rv[1] = 0;
      m_addr = '0; m_wdata = '0;
   endtask

   task automatic idle_inputs();
      p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
      p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_lock = 0;
   endtask

   // One clock: predict, compare at negedge, advance model at posedge.
   task automatic step();
      int g;
      bit s0, s1;
      logic [3:0]    ewe;
      logic [AW-1:0] ea;
      logic [31:0]   ewd, dv;
      @(negedge clk);
      s0 = p0_req && m_wait[0] >= SMAX;
      s1 = p1_req && m_wait[1] >= SMAX;
      if (s0) g = 0;
      else if (s1) g = 1;
      else if (m_locked && p1_req) g = 1;
      else if (p0_req && p1_req) g = (RR && m_ptr) ? 1 : 0;
      else if (p0_req) g = 0;
      else if (p1_req) g = 1;
      else g = -1;
      ewe = (g == 0) ? p0_we    : (g == 1) ? p1_we    : 4'h0;
      ea  = (g == 0) ? p0_addr  : (g == 1) ? p1_addr  : m_addr;
      ewd = (g == 0) ? p0_wdata : (g == 1) ? p1_wdata : m_wdata;
      obs_g0 = p0_gnt; obs_g1 = p1_gnt; obs_stall = cpu_stall;
      obs_rv0 = p0_rvalid; obs_rv1 = p1_rvalid;
      obs_rd0 = p0_rdata; obs_rd1 = p1_rdata;
      obs_we = dram_we; obs_addr = dram_addr; obs_wdata = dram_wdata;
      chk("gnt0", obs_g0, g == 0);
      chk("gnt1", obs_g1, g == 1);
      chk("stall", obs_stall, p0_req && g != 0);
      chk("dram_we", obs_we, ewe);
      chk("dram_addr", obs_addr, ea);
      chk("dram_wdata", obs_wdata, ewd);
      chk("rvalid0", obs_rv0, m_rv[0]);
      chk("rvalid1", obs_rv1, m_rv[1]);
      if (m_rv[0]) chk("rdata0", obs_rd0, m_rd[0]);
      if (m_rv[1]) chk("rdata1", obs_rd1, m_rd[1]);
      @(posedge clk);
      dv = dram_mem[obs_addr[3:0]];
      if (obs_we != 0)
         dram_mem[obs_addr[3:0]] = merge(dram_mem[obs_addr[3:0]], obs_wdata, obs_we);
      m_rv[0] = (g == 0) && p0_we == 0;
      m_rv[1] = (g == 1) && p1_we == 0;
      if (m_rv[0]) m_rd[0] = ref_mem[p0_addr[3:0]];
      if (m_rv[1]) m_rd[1] = ref_mem[p1_addr[3:0]];
      if (g >= 0 && ewe != 0)
         ref_mem[ea[3:0]] = merge(ref_mem[ea[3:0]], ewd, ewe);
      m_wait[0] = (!p0_req || g == 0) ? 0 : (m_wait[0] < SMAX ? m_wait[0] + 1 : SMAX);
      m_wait[1] = (!p1_req || g == 1) ? 0 : (m_wait[1] < SMAX ? m_wait[1] + 1 : SMAX);
      if (g >= 0) begin
         m_addr = ea; m_wdata = ewd; m_ptr = (g == 0);
      end
      if (m_locked) begin
         if (g == 1) m_beats++;
         if (!p1_lock || s0 || s1 || m_beats == LMAX) begin
            m_locked = 0; m_beats = 0; m_owner = -1;
         end
      end else begin
         if (g == 1 && m_owner == 1 && p1_lock) m_locked = 1;
         m_owner = g;
      end
      #1 dram_rdata = dv;
   endtask

   task automatic do_reset();
      rst = 1;
      idle_inputs();
      @(negedge clk);
      chk("rst_gnt0", p0_gnt, 0);
      chk("rst_gnt1", p1_gnt, 0);
      chk("rst_we", dram_we, 0);
      chk("rst_addr", dram_addr, 0);
      chk("rst_wdata", dram_wdata, 0);
      chk("rst_rv0", p0_rvalid, 0);
      chk("rst_rv1", p1_rvalid, 0);
      chk("rst_state", dut.r_state, IDLE);
      chk("rst_lock_cnt", dut.r_lock_cnt, 0);
      @(posedge clk);
      #1 rst = 0;
      m_reset();
   endtask

   task automatic drive_random();
      if (!p0_req || obs_g0) begin
         p0_req   = $urandom_range(0, 2) != 0;
         p0_we    = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
         p0_addr  = AW'($urandom);
         p0_wdata = $urandom;
      end
      if (!p1_req || obs_g1) begin
         p1_req   = $urandom_range(0, 2) != 0;
         p1_we    = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
         p1_addr  = AW'($urandom);
         p1_wdata = $urandom;
      end
      if ($urandom_range(0, 19) == 0) p1_lock = !p1_lock;
   endtask

   initial begin
      bit e;
      idle_inputs();
      dram_rdata = 0;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i]  = $urandom;
         dram_mem[i] = ref_mem[i];
      end
      m_reset();
      obs_g0 = 0; obs_g1 = 0;
      do_reset();

      // Uncontended read, same-cycle grant, data next cycle
      ref_mem[0] = 32'hDEADBEEF; dram_mem[0] = 32'hDEADBEEF;
      p0_req = 1; p0_we = 0; p0_addr = 16'h0010;
      step();
      chk("r034_gnt", obs_g0, 1);
      chk("r034_stall", obs_stall, 0);
      p0_req = 0;
      step();
      chk("r034_rvalid", obs_rv0, 1);
      chk("r034_rdata", obs_rd0, 32'hDEADBEEF);

      // Continuous contention
      do_reset();
      p0_req = 1; p1_req = 1; p0_addr = 16'h1; p1_addr = 16'h2;
      for (int i = 0; i < 18; i++) begin
         step();
         e = RR ? (i % 2 == 1) : (i % 9 == 8);
         chk($sformatf("r035_g1_%0d", i), obs_g1, e);
      end
      idle_inputs();
      step();

      // Lock beats bounded by LOCK_MAX
      do_reset();
      p1_req = 1; p1_lock = 1; p1_addr = 16'h3;
      for (int k = 1; k <= 20; k++) begin
         step();
         chk($sformatf("r036_g1_%0d", k), obs_g1, 1);
         if (k == 17) begin
            chk("r036_cnt17", dut.r_lock_cnt, 15);
            chk("r036_st17", dut.r_state, LOCK1);
         end
         if (k == 18) begin
            chk("r036_cnt18", dut.r_lock_cnt, 0);
            chk("r036_st18", dut.r_state, IDLE);
         end
      end
      idle_inputs();
      step();

      // Starvation breaks the lock
      do_reset();
      p1_req = 1; p1_lock = 1; p1_addr = 16'h7;
      step();
      step();
      p0_req = 1; p0_we = 0; p0_addr = 16'h5;
      for (int k = 1; k <= 9; k++) begin
         step();
         chk($sformatf("r037_stall_%0d", k), obs_stall, k < 9);
         chk($sformatf("r037_g0_%0d", k), obs_g0, k == 9);
      end
      idle_inputs();
      step();

      // Partial write, no rvalid, address held afterwards
      do_reset();
      p1_req = 1; p1_we = 4'b0011; p1_wdata = 32'h0000ABCD; p1_addr = 16'h0004;
      step();
      chk("r038_we", obs_we, 4'b0011);
      chk("r038_gnt1", obs_g1, 1);
      chk("r038_addr", obs_addr, 16'h0004);
      p1_req = 0; p1_we = 0;
      step();
      chk("r038_we_off", obs_we, 0);
      chk("r038_norv", obs_rv1, 0);
      chk("r038_hold", obs_addr, 16'h0004);

      // Reset right after a read grant
      do_reset();
      p0_req = 1; p0_we = 0; p0_addr = 16'h0006;
      step();
      chk("r039_gnt", obs_g0, 1);
      rst = 1;
      p0_req = 0;
      @(negedge clk);
      chk("r039_rv0", p0_rvalid, 0);
      chk("r039_gnt0", p0_gnt, 0);
      chk("r039_we", dram_we, 0);
      chk("r039_addr", dram_addr, 0);
      chk("r039_wdata", dram_wdata, 0);
      @(posedge clk);
      #1 rst = 0;
      m_reset();
      step();
      chk("r039_after", obs_rv0, 0);

      // Random traffic
      do_reset();
      obs_g0 = 0; obs_g1 = 0;
      for (int c = 0; c < 4000; c++) begin
         drive_random();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
